bitwise_logic_pipe: RTL

Parametrised, pipelined bitwise logic unit. It is the successor to the fixed 8-bit AND core behind the tt_um top-level wrapper. It generalises width and pipeline depth, selects among eight operations per transaction, and adds valid/ready flow control with backpressure and a running accumulator. It is instantiated directly by the tt_um wrapper: operands come from ui_in/uio_in, the result drives uo_out.

---
 rtl/bitwise_logic_pipe.sv | 102 ++++++++++
 1 files changed

// File: rtl/bitwise_logic_pipe.sv
// Purpose : pipelined bitwise logic unit (8 ops incl. LOAD/ACC_XOR accumulator) with valid/ready.
// Latency : STAGES cycles from the accept edge to out_valid, one result per cycle when unstalled.
// Backpr. : out_valid && !out_ready freezes every stage and drops in_ready; no in_valid->in_ready path.
module bitwise_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             busy
);

  localparam logic [2:0] OP_AND     = 3'd0;
  localparam logic [2:0] OP_OR      = 3'd1;
  localparam logic [2:0] OP_XOR     = 3'd2;
  localparam logic [2:0] OP_NAND    = 3'd3;
  localparam logic [2:0] OP_NOR     = 3'd4;
  localparam logic [2:0] OP_XNOR    = 3'd5;
  localparam logic [2:0] OP_LOAD    = 3'd6;
  localparam logic [2:0] OP_ACC_XOR = 3'd7;

  // Reject unsupported geometries at elaboration time.
  generate
    if (WIDTH < 1 || WIDTH > 32 || STAGES < 1 || STAGES > 4) begin : g_bad_param
      $error("bitwise_logic_pipe: WIDTH must be 1..32 and STAGES 1..4");
    end
  endgenerate

  logic              stall;
  logic              accept;
  logic [WIDTH-1:0]  result;
  logic [WIDTH-1:0]  acc;
  logic [STAGES-1:0] stg_vld;
  logic [WIDTH-1:0]  stg_dat [STAGES];

  // The whole pipe moves in lockstep, so a full output stage blocks everything behind it.
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

  // Operation decode; the accumulator is read here so back-to-back ACC_XOR sees the latest value.
  always_comb begin
    result = '0;
    case (op)
      OP_AND:     result = a & b;
      OP_OR:      result = a | b;
      OP_XOR:     result = a ^ b;
      OP_NAND:    result = ~(a & b);
      OP_NOR:     result = ~(a | b);
      OP_XNOR:    result = ~(a ^ b);
      OP_LOAD:    result = a;
      OP_ACC_XOR: result = acc ^ a;
      default:    result = '0;
    endcase
  end

  // Accumulator lives in the accept stage and only changes on an accepted LOAD/ACC_XOR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (accept && (op == OP_LOAD || op == OP_ACC_XOR)) begin
      acc <= result;
    end
  end

  // Stage shift: valid bits (bubbles included) always advance; data only follows a valid
  // entry so the output word keeps its last real value across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stg_dat[i] <= '0;
      end
    end else if (!stall) begin
      stg_vld[0] <= accept;
      if (accept) begin
        stg_dat[0] <= result;
      end
      for (int i = 1; i < STAGES; i++) begin
        stg_vld[i] <= stg_vld[i-1];
        if (stg_vld[i-1]) begin
          stg_dat[i] <= stg_dat[i-1];
        end
      end
    end
  end

  assign out_valid = stg_vld[STAGES-1];
  assign y         = stg_dat[STAGES-1];
  assign zero      = out_valid && (y == '0);
  assign busy      = |stg_vld;

endmodule
